prio_enc_arb: RTL and testbench

PRIO_ENC_ARB -- requirements
Module: prio_enc_arb

---
 rtl/prio_enc_arb.sv | 93 +++++++++
 tb/tb_prio_enc_arb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/prio_enc_arb.sv
// Registered priority encoder with a one-deep valid/ready output stage.
// Define PRIO_ENC_ARB_RR_EN for round-robin selection; otherwise the lowest set index wins.
module prio_enc_arb #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_vld,
  output logic         req_rdy,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_oh,
  output logic         grant_none,
  output logic         grant_vld,
  input  logic         grant_rdy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The result stage accepts a new request when empty or when its result is consumed.
  logic         load;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic [N-1:0] win_oh;

  assign req_rdy = !grant_vld | grant_rdy;
  assign load    = req_vld & req_rdy;

`ifdef PRIO_ENC_ARB_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] scan_idx;

  // Scan upward from ptr, wrapping N-1 -> 0; the first set bit wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = W'((int'(ptr) + i) % N);
      if (!win_found && req[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Pointer advances past the winner only when a non-empty request is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load && win_found) begin
      ptr <= (win_idx == W'(N-1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx   = W'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    win_oh = '0;
    if (win_found) begin
      win_oh[win_idx] = 1'b1;
    end
  end

  // Result registers only change on load; retiring without a new load just drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld  <= 1'b0;
      grant_idx  <= '0;
      grant_oh   <= '0;
      grant_none <= 1'b0;
    end else if (load) begin
      grant_vld  <= 1'b1;
      grant_idx  <= win_idx;
      grant_oh   <= win_oh;
      grant_none <= !win_found;
    end else if (grant_rdy) begin
      grant_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb (N=8): reset, selection, backpressure,
// empty request, back-to-back loads, async reset and (with PRIO_ENC_ARB_RR_EN) round-robin.
module tb_prio_enc_arb;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         req_vld;
  logic         req_rdy;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_oh;
  logic         grant_none;
  logic         grant_vld;
  logic         grant_rdy;

  int n_cmp;
  int n_fail;

  prio_enc_arb #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .grant_idx  (grant_idx),
    .grant_oh   (grant_oh),
    .grant_none (grant_none),
    .grant_vld  (grant_vld),
    .grant_rdy  (grant_rdy)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic vld, input logic [W-1:0] idx,
                            input logic [N-1:0] oh, input logic none);
    chk({tag, ".vld"},  64'(grant_vld),  64'(vld));
    chk({tag, ".idx"},  64'(grant_idx),  64'(idx));
    chk({tag, ".oh"},   64'(grant_oh),   64'(oh));
    chk({tag, ".none"}, 64'(grant_none), 64'(none));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = '0;
    req_vld   = 1'b0;
    grant_rdy = 1'b0;

    // Reset state
    #2;
    chk_result("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset.req_rdy", 64'(req_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed-priority selection: lowest set bit of 1010_0000 is 5
    @(negedge clk);
    req = 8'b1010_0000; req_vld = 1'b1; grant_rdy = 1'b1;
    tick();
    chk_result("sel_a0", 1'b1, 3'd5, 8'b0010_0000, 1'b0);

    // Backpressure for 4 cycles; req=01 offered but must not be captured
    grant_rdy = 1'b0; req = 8'h01; req_vld = 1'b1;
    #1;
    chk("bp.req_rdy0", 64'(req_rdy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_result($sformatf("bp%0d", i), 1'b1, 3'd5, 8'b0010_0000, 1'b0);
      chk($sformatf("bp%0d.req_rdy", i), 64'(req_rdy), 64'd0);
    end

    // Retire without new request: valid drops, results hold
    grant_rdy = 1'b1; req_vld = 1'b0;
    tick();
    chk_result("retire", 1'b0, 3'd5, 8'b0010_0000, 1'b0);
    chk("retire.req_rdy", 64'(req_rdy), 64'd1);

    // req=03: lowest index in fixed mode; with ptr=6 the RR scan wraps to 0
    req = 8'b0000_0011; req_vld = 1'b1;
    tick();
    chk_result("req03", 1'b1, 3'd0, 8'h01, 1'b0);
`ifdef PRIO_ENC_ARB_RR_EN
    chk("req03.ptr", 64'(dut.ptr), 64'd1);
`endif

    // Empty request
    req = 8'h00;
    tick();
    chk_result("empty", 1'b1, 3'd0, 8'h00, 1'b1);
`ifdef PRIO_ENC_ARB_RR_EN
    chk("empty.ptr", 64'(dut.ptr), 64'd1);
`endif

    // Back-to-back loads with no bubble
    req = 8'h80;
    tick();
    chk_result("b2b80", 1'b1, 3'd7, 8'h80, 1'b0);
    chk("b2b80.req_rdy", 64'(req_rdy), 64'd1);
    req = 8'h04;
    tick();
    chk_result("b2b04", 1'b1, 3'd2, 8'h04, 1'b0);
    req = 8'h10;
    tick();
    chk_result("b2b10", 1'b1, 3'd4, 8'h10, 1'b0);

    // Load a result and hold it, then assert reset between edges
    req = 8'h08;
    tick();
    grant_rdy = 1'b0; req_vld = 1'b0;
    chk_result("pre_rst", 1'b1, 3'd3, 8'h08, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_result("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("async_rst.req_rdy", 64'(req_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef PRIO_ENC_ARB_RR_EN
    chk("post_rst.ptr", 64'(dut.ptr), 64'd0);
`endif
    tick();
    chk("post_rst.vld", 64'(grant_vld), 64'd0);

    // All requests every cycle: RR rotates 0..7,0; fixed always picks 0
    req = 8'hFF; req_vld = 1'b1; grant_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [W-1:0] e;
`ifdef PRIO_ENC_ARB_RR_EN
      e = W'(i % N);
`else
      e = '0;
`endif
      tick();
      chk_result($sformatf("ff%0d", i), 1'b1, e, N'(1) << e, 1'b0);
    end

    req_vld = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
